// File: rtl/decode_pkg.sv
// Shared ISA constants, control-field struct and the combinational instruction decoder
// for the vector ASIP ID stage.
package decode_pkg;

  localparam int ISA_N        = 16;
  localparam int ISA_REG_BITS = 4;
  localparam int ISA_IMM_W    = 8;

  // Opcode classes: ALU is op[3]==0, jumps and memory ops are split on op[3:2]
  localparam logic       OP_ALU = 1'b0;
  localparam logic [1:0] OP_JMP = 2'b10;
  localparam logic [1:0] OP_MEM = 2'b11;

  typedef enum logic [1:0] {
    WR_MEM = 2'd0,
    WR_ALU = 2'd1,
    WR_IMM = 2'd2
  } wr_src_e;

  typedef struct packed {
    logic                    mem_write;
    logic                    mem_read;
    wr_src_e                 wr_from;
    logic [ISA_REG_BITS-1:0] rd;
    logic [ISA_IMM_W-1:0]    imm;
    logic                    reg_we_sc;
    logic                    reg_we_vec;
    logic [2:0]              pc_we;
    logic                    ovr_nz;
    logic [2:0]              alu_op;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [ISA_N-1:0] instr, input int vec_regs);
    ctrl_t      c;
    logic [3:0] op;
    logic       regwr;
    op           = instr[ISA_N-1 -: 4];
    c            = '0;
    c.rd         = instr[ISA_N-5 -: ISA_REG_BITS];
    c.imm        = instr[ISA_IMM_W-1:0];
    c.mem_write  = (op[3:2] == OP_MEM) & (op[1:0] == 2'b00);
    c.mem_read   = (op[3:2] == OP_MEM) & op[0];
    if (op[3] == OP_ALU)        c.wr_from = WR_ALU;
    else if (op[3:2] == OP_JMP) c.wr_from = WR_IMM;
    else                        c.wr_from = WR_MEM;
    regwr        = ~op[3] | (op[3] & op[2] & op[0]);
    c.reg_we_vec = regwr & (int'(c.rd) < vec_regs);
    c.reg_we_sc  = regwr & ~(int'(c.rd) < vec_regs);
    c.pc_we      = {op == 4'b1010, op == 4'b1000, op == 4'b1001};
    c.ovr_nz     = ~op[3] & (op[2:0] != 3'b000);
    c.alu_op     = op[2:0];
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// IF->ID and ID->EX handshake plus decoded control bundle of the ID stage.
// master = the decode stage, slave = its environment (IF/EX).
interface decode_stage_pipe_if #(
  parameter int N        = 16,
  parameter int REG_BITS = 4,
  parameter int IMM_W    = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [N-1:0]        instruction;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic                MemoryWrite;
  logic                MemoryRead;
  logic [1:0]          WriteRegFrom;
  logic [REG_BITS-1:0] RegToWrite;
  logic [IMM_W-1:0]    Immediate;
  logic                RegWriteEnSc;
  logic                RegWriteEnVec;
  logic [2:0]          PcWriteEn;
  logic                OverWriteNz;
  logic [2:0]          AluOpCode;
  logic                stall;

  modport master (
    input  in_valid, instruction, flush, out_ready,
    output in_ready, out_valid, MemoryWrite, MemoryRead, WriteRegFrom, RegToWrite,
           Immediate, RegWriteEnSc, RegWriteEnVec, PcWriteEn, OverWriteNz, AluOpCode, stall
  );

  modport slave (
    output in_valid, instruction, flush, out_ready,
    input  in_ready, out_valid, MemoryWrite, MemoryRead, WriteRegFrom, RegToWrite,
           Immediate, RegWriteEnSc, RegWriteEnVec, PcWriteEn, OverWriteNz, AluOpCode, stall
  );
endinterface

// File: rtl/decode_stage_pipe_load_scoreboard.sv
// Per-register load-latency down-counters; busy while a departed load's result is not
// yet forwardable.
module load_scoreboard #(
  parameter int REG_BITS = 4,
  parameter int LOAD_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     set,
  input  logic [REG_BITS-1:0]      set_idx,
  output logic [2**REG_BITS-1:0]   busy
);

  for (genvar r = 0; r < 2**REG_BITS; r++) begin : g_cnt
    logic [2:0] cnt;

    // A fresh load to the same register restarts the window rather than extending it
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  cnt <= 3'd0;
      else if (set && (set_idx == REG_BITS'(r)))   cnt <= 3'(LOAD_LAT);
      else if (cnt != 3'd0)                        cnt <= cnt - 3'd1;
    end

    assign busy[r] = (cnt != 3'd0);
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// ID stage: decodes the IF/ID word into control fields, registers them in ID/EX with
// valid/ready on both sides, EX flush, and a load-use stall from the scoreboard.
module decode_stage_pipe import decode_pkg::*; #(
  parameter int N        = ISA_N,
  parameter int REG_BITS = ISA_REG_BITS,
  parameter int IMM_W    = ISA_IMM_W,
  parameter int VEC_REGS = 4,
  parameter int LOAD_LAT = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  decode_stage_pipe_if.master bus
);

  ctrl_t                    dec, ctrl_q;
  logic                     out_valid_q;
  logic [REG_BITS-1:0]      rd_in;
  logic [2**REG_BITS-1:0]   busy;
  logic                     reads_rd, hazard, accept, ld_depart;

  assign dec      = decode(bus.instruction, VEC_REGS);
  assign rd_in    = bus.instruction[N-5 -: REG_BITS];

  // ALU ops and stores read rd, so only they can collide with an in-flight load
  assign reads_rd = (bus.instruction[N-1] == OP_ALU) | dec.mem_write;
  assign hazard   = bus.in_valid & reads_rd & busy[rd_in];

  assign bus.in_ready = (~out_valid_q | bus.out_ready) & ~hazard;
  assign accept       = bus.in_valid & bus.in_ready;
  assign bus.stall    = hazard & (~out_valid_q | bus.out_ready);
  assign ld_depart    = out_valid_q & bus.out_ready & ctrl_q.mem_read & ~bus.flush;

  // Flush beats accept: the word is consumed from IF but never reaches EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      ctrl_q      <= dec;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  load_scoreboard #(
    .REG_BITS (REG_BITS),
    .LOAD_LAT (LOAD_LAT)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set     (ld_depart),
    .set_idx (ctrl_q.rd[REG_BITS-1:0]),
    .busy    (busy)
  );

  assign bus.out_valid     = out_valid_q;
  assign bus.MemoryWrite   = ctrl_q.mem_write;
  assign bus.MemoryRead    = ctrl_q.mem_read;
  assign bus.WriteRegFrom  = ctrl_q.wr_from;
  assign bus.RegToWrite    = ctrl_q.rd[REG_BITS-1:0];
  assign bus.Immediate     = ctrl_q.imm[IMM_W-1:0];
  assign bus.RegWriteEnSc  = ctrl_q.reg_we_sc;
  assign bus.RegWriteEnVec = ctrl_q.reg_we_vec;
  assign bus.PcWriteEn     = ctrl_q.pc_we;
  assign bus.OverWriteNz   = ctrl_q.ovr_nz;
  assign bus.AluOpCode     = ctrl_q.alu_op;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: reset, decode fields, load-use stall,
// backpressure, flush, VEC_REGS split and asynchronous reset.
module tb_decode_stage_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decode_stage_pipe_if #(.N(16), .REG_BITS(4), .IMM_W(8)) bus ();
  decode_stage_pipe_if #(.N(16), .REG_BITS(4), .IMM_W(8)) bus8 ();

  decode_stage_pipe #(.VEC_REGS(4), .LOAD_LAT(2)) dut (
    .clk (clk), .rst_n (rst_n), .bus (bus)
  );
  decode_stage_pipe #(.VEC_REGS(8), .LOAD_LAT(2)) dut8 (
    .clk (clk), .rst_n (rst_n), .bus (bus8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {mw, mr, wrfrom, rd, imm, sc, vec, pcwe, nz, aluop}
  function automatic logic [24:0] pack(input logic mw, input logic mr, input logic [1:0] wrf,
                                       input logic [3:0] rd, input logic [7:0] imm,
                                       input logic sc, input logic vec, input logic [2:0] pc,
                                       input logic nz, input logic [2:0] alu);
    return {mw, mr, wrf, rd, imm, sc, vec, pc, nz, alu};
  endfunction

  function automatic logic [24:0] ex_fields();
    return {bus.MemoryWrite, bus.MemoryRead, bus.WriteRegFrom, bus.RegToWrite, bus.Immediate,
            bus.RegWriteEnSc, bus.RegWriteEnVec, bus.PcWriteEn, bus.OverWriteNz, bus.AluOpCode};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1; bus.instruction = 16'h0312; bus.flush = 1'b0; bus.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.instruction = 16'h0000; bus8.flush = 1'b0; bus8.out_ready = 1'b1;
    tick(); tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    checks++;
    if (ex_fields() !== 25'd0) begin errors++; $display("FAIL reset_fields: got %h want 0", ex_fields()); end
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_alu_issue();
    bus.in_valid = 1'b1; bus.instruction = 16'h0312; bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL alu_in_ready: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL alu_valid: got %b want 1", bus.out_valid); end
    checks++;
    if (ex_fields() !== pack(0, 0, 2'd1, 4'd3, 8'h12, 0, 1, 3'b000, 0, 3'd0))
      begin errors++; $display("FAIL alu_fields: got %h want %h", ex_fields(), pack(0, 0, 2'd1, 4'd3, 8'h12, 0, 1, 3'b000, 0, 3'd0)); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL alu_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_load_use();
    bus.in_valid = 1'b1; bus.instruction = 16'hD512; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.out_valid, ex_fields()} !== {1'b1, pack(0, 1, 2'd0, 4'd5, 8'h12, 1, 0, 3'b000, 0, 3'd5)})
      begin errors++; $display("FAIL load_fields: got %h want %h", {bus.out_valid, ex_fields()}, {1'b1, pack(0, 1, 2'd0, 4'd5, 8'h12, 1, 0, 3'b000, 0, 3'd5)}); end
    tick();
    // load has left ID/EX; the dependent ALU op arrives while r5 is busy
    bus.in_valid = 1'b1; bus.instruction = 16'h1500;
    #1;
    checks++;
    if ({bus.stall, bus.in_ready} !== 2'b10) begin errors++; $display("FAIL lu_stall1: got %b want 10", {bus.stall, bus.in_ready}); end
    tick();
    checks++;
    if ({bus.stall, bus.in_ready, bus.out_valid} !== 3'b100) begin errors++; $display("FAIL lu_stall2: got %b want 100", {bus.stall, bus.in_ready, bus.out_valid}); end
    tick();
    checks++;
    if ({bus.stall, bus.in_ready, bus.out_valid} !== 3'b010) begin errors++; $display("FAIL lu_release: got %b want 010", {bus.stall, bus.in_ready, bus.out_valid}); end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.out_valid, ex_fields()} !== {1'b1, pack(0, 0, 2'd1, 4'd5, 8'h00, 1, 0, 3'b000, 1, 3'd1)})
      begin errors++; $display("FAIL lu_issue: got %h want %h", {bus.out_valid, ex_fields()}, {1'b1, pack(0, 0, 2'd1, 4'd5, 8'h00, 1, 0, 3'b000, 1, 3'd1)}); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [24:0] fa, fb;
    fa = pack(0, 0, 2'd1, 4'd3, 8'h45, 0, 1, 3'b000, 1, 3'd2);
    fb = pack(0, 0, 2'd1, 4'd4, 8'h56, 1, 0, 3'b000, 1, 3'd3);
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.instruction = 16'h2345;
    tick();
    bus.instruction = 16'h3456;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, ex_fields()} !== {2'b10, fa})
        begin errors++; $display("FAIL bp_hold%0d: got %h want %h", i, {bus.out_valid, bus.in_ready, ex_fields()}, {2'b10, fa}); end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.out_valid, ex_fields()} !== {1'b1, fb}) begin errors++; $display("FAIL bp_next: got %h want %h", {bus.out_valid, ex_fields()}, {1'b1, fb}); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    logic [24:0] fj;
    fj = pack(0, 0, 2'd2, 4'd0, 8'h00, 0, 0, 3'b100, 0, 3'd2);
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.instruction = 16'hA000;
    tick();
    checks++;
    if ({bus.out_valid, ex_fields()} !== {1'b1, fj}) begin errors++; $display("FAIL jmp_fields: got %h want %h", {bus.out_valid, ex_fields()}, {1'b1, fj}); end
    bus.flush = 1'b1; bus.instruction = 16'h0777;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", bus.in_ready); end
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    checks++;
    if ({bus.out_valid, ex_fields()} !== {1'b0, fj}) begin errors++; $display("FAIL flush_drop: got %h want %h", {bus.out_valid, ex_fields()}, {1'b0, fj}); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_after: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_vec_regs();
    bus.in_valid = 1'b1; bus8.in_valid = 1'b1; bus.out_ready = 1'b1;
    bus.instruction = 16'h0300; bus8.instruction = 16'h0300;
    tick();
    checks++;
    if ({bus.RegWriteEnVec, bus.RegWriteEnSc, bus8.RegWriteEnVec, bus8.RegWriteEnSc} !== 4'b1010)
      begin errors++; $display("FAIL vec_rd3: got %b want 1010", {bus.RegWriteEnVec, bus.RegWriteEnSc, bus8.RegWriteEnVec, bus8.RegWriteEnSc}); end
    bus.instruction = 16'h0400; bus8.instruction = 16'h0400;
    tick();
    checks++;
    if ({bus.RegWriteEnVec, bus.RegWriteEnSc, bus8.RegWriteEnVec, bus8.RegWriteEnSc} !== 4'b0110)
      begin errors++; $display("FAIL vec_rd4: got %b want 0110", {bus.RegWriteEnVec, bus.RegWriteEnSc, bus8.RegWriteEnVec, bus8.RegWriteEnSc}); end
    bus.instruction = 16'h0800; bus8.instruction = 16'h0800;
    tick();
    checks++;
    if ({bus.RegWriteEnVec, bus.RegWriteEnSc, bus8.RegWriteEnVec, bus8.RegWriteEnSc} !== 4'b0101)
      begin errors++; $display("FAIL vec_rd8: got %b want 0101", {bus.RegWriteEnVec, bus.RegWriteEnSc, bus8.RegWriteEnVec, bus8.RegWriteEnSc}); end
    bus.in_valid = 1'b0; bus8.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.instruction = 16'hD512;
    tick();
    bus.instruction = 16'h0312;
    tick();
    // load to r5 departed this edge; a store reading r5 must now stall
    bus.instruction = 16'hC500;
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.stall} !== 3'b101)
      begin errors++; $display("FAIL ar_pre: got %b want 101", {bus.out_valid, bus.in_ready, bus.stall}); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.stall} !== 3'b010)
      begin errors++; $display("FAIL ar_async: got %b want 010", {bus.out_valid, bus.in_ready, bus.stall}); end
    checks++;
    if (ex_fields() !== 25'd0) begin errors++; $display("FAIL ar_fields: got %h want 0", ex_fields()); end
    bus.in_valid = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ar_after: got %b want 0", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_alu_issue();
    test_load_use();
    test_backpressure();
    test_flush();
    test_vec_regs();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
